id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage; consumes the fetch latch outputs (id_instr, id_instr_addr) and drives the ID/EX pipeline latch.
- Holds the 8x16 register file and a per-register scoreboard interlock.
- Resolves BEQ/JMP in ID and generates the fetch-side controls: PC_WR_EN, FE_LATCH_WR, ctr_sig, branch target, flush.
- Accepts writeback from the final stage.

Parameters:
- DATA_W, 16, datapath and instruction width.
- NUM_REGS, 8, architectural registers (3-bit specifiers); r0 reads as 0.
- HALT_OPCODE, 4'hF, opcode that stops fetch.

Ports:
- CLOCK_50  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_instr  in  16  instruction from the fetch latch.
- id_instr_addr  in  16  PC+2 of id_instr.
- wb_en  in  1  register write strobe.
- wb_reg  in  3  write register.
- wb_data  in  16  write data.
- PC_WR_EN  out  1  PC write enable.
- FE_LATCH_WR  out  1  fetch latch write enable.
- ctr_sig  out  2  PC select: 0 = sequential, 1 = branch/jump target.
- br_target  out  16  redirect address.
- id_flush  out  1  squash the instruction in the fetch latch.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_op  out  4  opcode.
- ex_rd  out  3  destination register.
- ex_a  out  16  rs value.
- ex_b  out  16  rt value (SW: store data).
- ex_imm  out  16  sign-extended imm6.
- ex_pc  out  16  id_instr_addr.
- halted  out  1  HALT reached.

Behaviour:
- Instruction fields:
  - op [15:12], rd [11:9], rs [8:6], rt [5:3], imm6 [5:0].
  - JMP uses imm12 [11:0].
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: rd <= rs op rt.
  - 4 ADDI, 5 LW: rd written; source rs only.
  - 6 SW: sources rs, rt; no write.
  - 7 BEQ: sources rd, rs; no write.
  - 8 JMP: no sources.
  - HALT_OPCODE: halt.
  - All other opcodes are NOP.
- Reset (reset=0, asynchronous):
  - All registers, scoreboard, ID/EX fields and halted clear to 0.
  - State = RUN.
- FSM states: RUN, HALT. There is no exit from HALT except reset.
- Register file:
  - Written on the clock edge when wb_en=1 and wb_reg!=0.
  - Writes to r0 are ignored; r0 always reads 0.
  - Reads are combinational.
- Scoreboard pend[7:1]:
  - Set when a register-writing instruction enters ID/EX.
  - Cleared on the wb_en edge for wb_reg.
  - Set and clear on the same register in the same cycle: result is set (new issue wins).
- stall = RUN and (any source pending, or a writer's rd pending (WAW)). r0 is never pending.
- On stall:
  - PC_WR_EN=0, FE_LATCH_WR=0, ctr_sig=0.
  - ID/EX is loaded with a bubble: ex_valid=0, all other fields 0.
- No stall (RUN):
  - PC_WR_EN=1, FE_LATCH_WR=1.
  - ID/EX is loaded with the decoded fields and ex_valid=1 (NOP: ex_valid=0).
- BEQ taken (rd value == rs value, not stalled):
  - ctr_sig=1, br_target = id_instr_addr + (sext(imm6)<<1), id_flush=1.
  - The next ID cycle then presents a squashed instruction, which is treated as a NOP.
  - BEQ not taken: ctr_sig=0.
- JMP: ctr_sig=1, br_target = {id_instr_addr[15:13], imm12, 1'b0}, id_flush=1.
- All 16-bit address arithmetic wraps modulo 2^16.
- HALT (not squashed):
  - Next state HALT; halted=1 from the following cycle.
  - In HALT: PC_WR_EN=0, FE_LATCH_WR=0, ex_valid=0.
  - Writebacks are still accepted.
- A squashed slot never sets the scoreboard, never branches and never halts.
- Reset asserted mid-stall or mid-branch clears everything immediately, with no residual flush.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - A same-cycle writeback is forwarded to the register read ports (wb_data is used when wb_reg matches rs/rt/rd, wb_en=1, reg!=0).
  - The matching pend bit is treated as already clear for the stall decision.
  - Result: a dependent instruction issues in the writeback cycle.
- Undefined:
  - Reads see only previously written values.
  - The dependent instruction stalls until the cycle after writeback (one extra stall cycle).

Test Plan:
- Reset: release reset with id_instr=ADD r1,r2,r3 -> ex_valid=1, ex_rd=1, ex_a=0, ex_b=0, PC_WR_EN=1, pend[1]=1.
- RAW interlock: ADD r1 issued, then ADD r4,r1,r2 in ID -> PC_WR_EN=0, FE_LATCH_WR=0, bubble each cycle; wb_en=1, wb_reg=1, wb_data=16'h0005 -> issue with ex_a=5. The issue happens in the same cycle with ID_WB_BYPASS_EN, and one cycle later without it.
- BEQ taken: r1=r2=7, id_instr_addr=16'h0010, imm6=6'h3E -> ctr_sig=1, br_target=16'h000C, id_flush=1; the following instruction is squashed (ex_valid=0).
- JMP wrap: id_instr_addr=16'hE002, imm12=12'hFFF -> br_target=16'hFFFE.
- r0 handling: wb_en to r0 with data 16'hFFFF, then ADD r2,r0,r0 -> ex_a=0, ex_b=0, no stall.
- HALT: HALT in ID -> next cycle halted=1, PC_WR_EN=0, FE_LATCH_WR=0 for 20 cycles; reset low mid-HALT -> halted=0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : instruction-decode stage
//
// Decodes the instruction held in the fetch latch, reads the 8x16 register
// file, interlocks on a per-register scoreboard, resolves BEQ/JMP and drives
// the fetch-side controls plus the ID/EX pipeline latch. Writeback from the
// final stage updates the register file and clears scoreboard bits.
//
// Ports
//   CLOCK_50        clock, rising edge
//   reset           asynchronous, active-low reset
//   id_instr        instruction from the fetch latch
//   id_instr_addr   PC+2 of id_instr
//   wb_en/wb_reg/wb_data   register writeback
//   PC_WR_EN, FE_LATCH_WR  fetch advance enables (0 while stalled/halted)
//   ctr_sig         PC select: 0 sequential, 1 branch/jump target
//   br_target       redirect address
//   id_flush        squash the instruction in the fetch latch
//   ex_*            ID/EX latch (valid, op, rd, rs value, rt value, imm, pc)
//   halted          HALT reached
//
// Build option
//   ID_WB_BYPASS_EN : forward a same-cycle writeback to the read ports and
//                     treat its scoreboard bit as already clear.
// -----------------------------------------------------------------------------
module id_stage #(
   parameter int          DATA_W      = 16,
   parameter int          NUM_REGS    = 8,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [DATA_W-1:0] id_instr,
   input  logic [DATA_W-1:0] id_instr_addr,
   input  logic              wb_en,
   input  logic [2:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              PC_WR_EN,
   output logic              FE_LATCH_WR,
   output logic [1:0]        ctr_sig,
   output logic [DATA_W-1:0] br_target,
   output logic              id_flush,
   output logic              ex_valid,
   output logic [3:0]        ex_op,
   output logic [2:0]        ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic              halted
);

`ifdef ID_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t                state_reg;
   logic                  squash_reg;      // current ID slot is a squashed fetch
   logic [NUM_REGS-1:1]   pend_reg;
   logic [DATA_W-1:0]     rf [NUM_REGS];

   // instruction fields
   logic [3:0]        op;
   logic [2:0]        rd, rs, rt;
   logic [DATA_W-1:0] imm_sext;
   assign op       = id_instr[15:12];
   assign rd       = id_instr[11:9];
   assign rs       = id_instr[8:6];
   assign rt       = id_instr[5:3];
   assign imm_sext = {{10{id_instr[5]}}, id_instr[5:0]};

   // decode
   logic uses_rs, uses_rt, uses_rd, writes_rd, is_beq, is_jmp, is_halt, is_real;
   always_comb begin
      uses_rs   = 1'b0;
      uses_rt   = 1'b0;
      uses_rd   = 1'b0;
      writes_rd = 1'b0;
      is_beq    = 1'b0;
      is_jmp    = 1'b0;
      is_halt   = 1'b0;
      is_real   = 1'b0;
      if (op == HALT_OPCODE) begin
         is_halt = 1'b1;
         is_real = 1'b1;
      end else begin
         case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
               uses_rs = 1'b1; uses_rt = 1'b1; writes_rd = 1'b1; is_real = 1'b1;
            end
            4'h4, 4'h5: begin
               uses_rs = 1'b1; writes_rd = 1'b1; is_real = 1'b1;
            end
            4'h6: begin
               uses_rs = 1'b1; uses_rt = 1'b1; is_real = 1'b1;
            end
            4'h7: begin
               uses_rd = 1'b1; uses_rs = 1'b1; is_beq = 1'b1; is_real = 1'b1;
            end
            4'h8: begin
               is_jmp = 1'b1; is_real = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // one-hot writeback and scoreboard-set vectors; bit 0 (r0) is never used
   logic [NUM_REGS-1:0] wb_hit, pend_set, pend_full, pend_eff;
   logic                go;
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
         if (gi == 0) begin : g_r0
            assign wb_hit[gi]   = 1'b0;
            assign pend_set[gi] = 1'b0;
         end else begin : g_rn
            assign wb_hit[gi]   = wb_en && (wb_reg == 3'(gi));
            assign pend_set[gi] = go && writes_rd && (rd == 3'(gi));
         end
      end
   endgenerate

   assign pend_full = {pend_reg, 1'b0};
   assign pend_eff  = BYPASS ? (pend_full & ~wb_hit) : pend_full;

   // combinational read ports; r0 is forced to zero
   logic [DATA_W-1:0] rs_val, rt_val, rd_val;
   assign rs_val = (rs == 3'd0) ? '0 : (BYPASS && wb_hit[rs]) ? wb_data : rf[rs];
   assign rt_val = (rt == 3'd0) ? '0 : (BYPASS && wb_hit[rt]) ? wb_data : rf[rt];
   assign rd_val = (rd == 3'd0) ? '0 : (BYPASS && wb_hit[rd]) ? wb_data : rf[rd];

   // a squashed slot has no sources, so it can never stall
   logic run, live, stall, beq_taken, jmp_taken;
   assign run   = (state_reg == S_RUN);
   assign live  = run && !squash_reg;
   assign stall = live && ((uses_rs && pend_eff[rs]) || (uses_rt && pend_eff[rt]) ||
                           ((uses_rd || writes_rd) && pend_eff[rd]));
   assign go        = live && !stall;
   assign beq_taken = go && is_beq && (rd_val == rs_val);
   assign jmp_taken = go && is_jmp;

   assign PC_WR_EN    = run && !stall;
   assign FE_LATCH_WR = run && !stall;
   assign ctr_sig     = (beq_taken || jmp_taken) ? 2'd1 : 2'd0;
   assign id_flush    = beq_taken || jmp_taken;
   assign br_target   = is_jmp ? {id_instr_addr[15:13], id_instr[11:0], 1'b0}
                               : id_instr_addr + {imm_sext[14:0], 1'b0};

   // register file
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_hit[i]) rf[i] <= wb_data;
         end
      end
   end

   // state, scoreboard and ID/EX latch
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_RUN;
         halted     <= 1'b0;
         squash_reg <= 1'b0;
         pend_reg   <= '0;
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         ex_rd      <= '0;
         ex_a       <= '0;
         ex_b       <= '0;
         ex_imm     <= '0;
         ex_pc      <= '0;
      end else begin
         // a new issue wins over a same-cycle writeback clear
         pend_reg   <= ((pend_full & ~wb_hit) | pend_set) >> 1;
         squash_reg <= beq_taken || jmp_taken;
         if (go && is_halt) begin
            state_reg <= S_HALT;
            halted    <= 1'b1;
         end
         if (go && is_real) begin
            ex_valid <= 1'b1;
            ex_op    <= op;
            ex_rd    <= writes_rd ? rd : 3'd0;
            ex_a     <= rs_val;
            ex_b     <= rt_val;
            ex_imm   <= imm_sext;
            ex_pc    <= id_instr_addr;
         end else begin
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [15:0] id_instr, id_instr_addr, wb_data;
   logic        wb_en;
   logic [2:0]  wb_reg;
   logic        PC_WR_EN, FE_LATCH_WR, id_flush, ex_valid, halted;
   logic [1:0]  ctr_sig;
   logic [15:0] br_target, ex_a, ex_b, ex_imm, ex_pc;
   logic [3:0]  ex_op;
   logic [2:0]  ex_rd;

   int total = 0;
   int bad   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   id_stage dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .id_instr(id_instr), .id_instr_addr(id_instr_addr),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .PC_WR_EN(PC_WR_EN), .FE_LATCH_WR(FE_LATCH_WR), .ctr_sig(ctr_sig),
      .br_target(br_target), .id_flush(id_flush),
      .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a),
      .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc), .halted(halted)
   );

   // chk: 0 = only ex_valid, 1 = all ex fields, 2 = all ex fields except ex_rd
   typedef struct {
      logic [15:0] instr, addr;
      logic        wb_en;
      logic [2:0]  wb_reg;
      logic [15:0] wb_data;
      logic        pc_en;
      logic [1:0]  ctr;
      logic        flush;
      logic [15:0] br;
      int          chk;
      logic        valid;
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [15:0] a, b, imm, pc;
   } vec_t;

   vec_t vq[$];

   localparam logic [15:0] NOP = 16'h9000;

   function automatic logic [15:0] r3(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s, input logic [2:0] t);
      return {op, d, s, t, 3'b000};
   endfunction

   function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s, input logic [5:0] imm);
      return {op, d, s, imm};
   endfunction

   function automatic vec_t mk(
      input logic [15:0] instr, input logic [15:0] addr,
      input logic we, input logic [2:0] wr, input logic [15:0] wd,
      input logic pc_en, input logic [1:0] ctr, input logic flush, input logic [15:0] br,
      input int chk, input logic valid, input logic [3:0] op, input logic [2:0] rd,
      input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
      input logic [15:0] pc);
      vec_t v;
      v.instr = instr; v.addr = addr; v.wb_en = we; v.wb_reg = wr; v.wb_data = wd;
      v.pc_en = pc_en; v.ctr = ctr; v.flush = flush; v.br = br; v.chk = chk;
      v.valid = valid; v.op = op; v.rd = rd; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d act=%0h exp=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] instr, input logic [15:0] addr,
                        input logic we, input logic [2:0] wr, input logic [15:0] wd);
      id_instr = instr; id_instr_addr = addr;
      wb_en = we; wb_reg = wr; wb_data = wd;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge CLOCK_50);
      drive(v.instr, v.addr, v.wb_en, v.wb_reg, v.wb_data);
      #1;
      chk("PC_WR_EN", idx, PC_WR_EN, v.pc_en);
      chk("FE_LATCH_WR", idx, FE_LATCH_WR, v.pc_en);
      chk("ctr_sig", idx, ctr_sig, v.ctr);
      chk("id_flush", idx, id_flush, v.flush);
      if (v.ctr == 2'd1) chk("br_target", idx, br_target, v.br);
      @(posedge CLOCK_50);
      #1;
      chk("ex_valid", idx, ex_valid, v.valid);
      chk("halted", idx, halted, 1'b0);
      if (v.chk != 0) begin
         chk("ex_op", idx, ex_op, v.op);
         chk("ex_a", idx, ex_a, v.a);
         chk("ex_b", idx, ex_b, v.b);
         chk("ex_imm", idx, ex_imm, v.imm);
         chk("ex_pc", idx, ex_pc, v.pc);
         if (v.chk == 1) chk("ex_rd", idx, ex_rd, v.rd);
      end
      $display("step %0d instr=%h addr=%h wb=%0b/r%0d pc_en=%0b ctr=%0d ex_valid=%0b ex_a=%h",
               idx, v.instr, v.addr, v.wb_en, v.wb_reg, PC_WR_EN, ctr_sig, ex_valid, ex_a);
   endtask

   initial begin
      reset = 1'b0;
      drive(NOP, 16'h0000, 1'b0, 3'd0, 16'h0000);

      // ---------------- vector table ----------------
      // issue out of reset
      vq.push_back(mk(r3(4'h0,3'd1,3'd2,3'd3), 16'h0002, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h0,3'd1,16'h0,16'h0,16'h0018,16'h0002));
      // RAW on r1: stall with bubbles
      vq.push_back(mk(r3(4'h0,3'd4,3'd1,3'd2), 16'h0004, 1'b0,3'd0,16'h0,
                      1'b0,2'd0,1'b0,16'h0, 1, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(r3(4'h0,3'd4,3'd1,3'd2), 16'h0004, 1'b0,3'd0,16'h0,
                      1'b0,2'd0,1'b0,16'h0, 1, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
`ifdef ID_WB_BYPASS_EN
      vq.push_back(mk(r3(4'h0,3'd4,3'd1,3'd2), 16'h0004, 1'b1,3'd1,16'h0005,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h0,3'd4,16'h0005,16'h0,16'h0010,16'h0004));
`else
      vq.push_back(mk(r3(4'h0,3'd4,3'd1,3'd2), 16'h0004, 1'b1,3'd1,16'h0005,
                      1'b0,2'd0,1'b0,16'h0, 1, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(r3(4'h0,3'd4,3'd1,3'd2), 16'h0004, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h0,3'd4,16'h0005,16'h0,16'h0010,16'h0004));
`endif
      // writebacks: r4=9, r2=7, r1=7
      vq.push_back(mk(NOP, 16'h0006, 1'b1,3'd4,16'h0009, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(NOP, 16'h0008, 1'b1,3'd2,16'h0007, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(NOP, 16'h000A, 1'b1,3'd1,16'h0007, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      // BEQ r1,r2 taken, negative offset
      vq.push_back(mk(ri(4'h7,3'd1,3'd2,6'h3E), 16'h0010, 1'b0,3'd0,16'h0,
                      1'b1,2'd1,1'b1,16'h000C, 0, 1'b1,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      // squashed slot: no issue, no scoreboard set for r5
      vq.push_back(mk(r3(4'h0,3'd5,3'd4,3'd4), 16'h0012, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      // reads r5 (must not be pending) and r4=9; negative imm sign-extension
      vq.push_back(mk(r3(4'h0,3'd6,3'd5,3'd4), 16'h000C, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h0,3'd6,16'h0,16'h0009,16'hFFE0,16'h000C));
      // BEQ r4,r1 not taken (9 vs 7)
      vq.push_back(mk(ri(4'h7,3'd4,3'd1,6'h01), 16'h0020, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 0, 1'b1,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      // JMP with upper-bit splice
      vq.push_back(mk(16'h8FFF, 16'hE002, 1'b0,3'd0,16'h0,
                      1'b1,2'd1,1'b1,16'hFFFE, 0, 1'b1,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      // squashed HALT must not halt
      vq.push_back(mk(16'hF000, 16'hFFFE, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      // write to r0 ignored
      vq.push_back(mk(NOP, 16'h0000, 1'b1,3'd0,16'hFFFF, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(r3(4'h0,3'd2,3'd0,3'd0), 16'h0040, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h0,3'd2,16'h0,16'h0,16'h0,16'h0040));
      // SW stalls on pending store-data r6
      vq.push_back(mk(r3(4'h6,3'd1,3'd0,3'd6), 16'h0042, 1'b0,3'd0,16'h0,
                      1'b0,2'd0,1'b0,16'h0, 1, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(NOP, 16'h0042, 1'b1,3'd6,16'h1234, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(r3(4'h6,3'd1,3'd0,3'd6), 16'h0042, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 2, 1'b1,4'h6,3'd0,16'h0,16'h1234,16'hFFF0,16'h0042));
      // WAW on r2
      vq.push_back(mk(ri(4'h4,3'd2,3'd0,6'h01), 16'h0044, 1'b0,3'd0,16'h0,
                      1'b0,2'd0,1'b0,16'h0, 1, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(NOP, 16'h0044, 1'b1,3'd2,16'h0003, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(ri(4'h4,3'd2,3'd0,6'h01), 16'h0044, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h4,3'd2,16'h0,16'h0,16'h0001,16'h0044));
      // issue r7 while r7 is being written back: pending must stay set
      vq.push_back(mk(ri(4'h4,3'd7,3'd0,6'h05), 16'h0046, 1'b1,3'd7,16'h0055,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h4,3'd7,16'h0,16'h0,16'h0005,16'h0046));
      vq.push_back(mk(r3(4'h0,3'd3,3'd7,3'd0), 16'h0048, 1'b0,3'd0,16'h0,
                      1'b0,2'd0,1'b0,16'h0, 1, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(NOP, 16'h0048, 1'b1,3'd7,16'h0066, 1'b1,2'd0,1'b0,16'h0, 0, 1'b0,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0));
      vq.push_back(mk(r3(4'h0,3'd3,3'd7,3'd0), 16'h0048, 1'b0,3'd0,16'h0,
                      1'b1,2'd0,1'b0,16'h0, 1, 1'b1,4'h0,3'd3,16'h0066,16'h0,16'h0,16'h0048));

      // ---------------- reset state ----------------
      repeat (2) @(posedge CLOCK_50);
      #1;
      chk("rst_ex_valid", 0, ex_valid, 1'b0);
      chk("rst_halted", 0, halted, 1'b0);
      chk("rst_ex_a", 0, ex_a, 16'h0);
      @(negedge CLOCK_50);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i + 1);

      // ---------------- reset in the middle of a jump ----------------
      apply(mk(16'h8005, 16'h0100, 1'b0,3'd0,16'h0,
               1'b1,2'd1,1'b1,16'h000A, 0, 1'b1,4'h0,3'd0,16'h0,16'h0,16'h0,16'h0), 100);
      #2 reset = 1'b0;
      #1;
      chk("midbr_ex_valid", 101, ex_valid, 1'b0);
      chk("midbr_ex_pc", 101, ex_pc, 16'h0);
      @(negedge CLOCK_50);
      reset = 1'b1;
      drive(r3(4'h0,3'd1,3'd2,3'd3), 16'h0200, 1'b0, 3'd0, 16'h0);
      #1;
      chk("midbr_PC_WR_EN", 102, PC_WR_EN, 1'b1);
      @(posedge CLOCK_50);
      #1;
      chk("midbr_ex_valid", 102, ex_valid, 1'b1);
      chk("midbr_ex_rd", 102, ex_rd, 3'd1);
      chk("midbr_ex_a", 102, ex_a, 16'h0);     // r2 was 3 before reset
      $display("step 102 post-reset issue ex_valid=%0b ex_a=%h", ex_valid, ex_a);

      // ---------------- HALT ----------------
      @(negedge CLOCK_50);
      drive(16'hF000, 16'h0030, 1'b0, 3'd0, 16'h0);
      #1;
      chk("halt_PC_WR_EN", 103, PC_WR_EN, 1'b1);
      @(posedge CLOCK_50);
      #1;
      chk("halt_halted", 103, halted, 1'b1);
      chk("halt_PC_WR_EN_after", 103, PC_WR_EN, 1'b0);
      $display("step 103 HALT halted=%0b", halted);
      for (int c = 0; c < 20; c++) begin
         @(negedge CLOCK_50);
         drive(r3(4'h0,3'd5,3'd0,3'd0), 16'h0032, 1'b1, 3'd5, 16'h00AA);
         #1;
         chk("inhalt_PC_WR_EN", 104 + c, PC_WR_EN, 1'b0);
         chk("inhalt_FE_LATCH_WR", 104 + c, FE_LATCH_WR, 1'b0);
         @(posedge CLOCK_50);
         #1;
         chk("inhalt_halted", 104 + c, halted, 1'b1);
         chk("inhalt_ex_valid", 104 + c, ex_valid, 1'b0);
         $display("step %0d in HALT halted=%0b pc_en=%0b", 104 + c, halted, PC_WR_EN);
      end
      #2 reset = 1'b0;
      #1;
      chk("halt_reset_halted", 130, halted, 1'b0);
      @(negedge CLOCK_50);
      drive(NOP, 16'h0000, 1'b0, 3'd0, 16'h0);
      reset = 1'b1;
      #1;
      chk("halt_reset_PC_WR_EN", 131, PC_WR_EN, 1'b1);
      @(posedge CLOCK_50);
      #1;
      chk("halt_reset_stays", 131, halted, 1'b0);
      $display("step 131 after reset halted=%0b", halted);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
